program_memory: RTL and testbench

- Instruction/program store for the Never8 8-bit core. It is a 256 x 8 memory with a synchronous, registered read port indexed by the program counter.
- A synchronous load port lets a loader or bench overwrite bytes.
- Power-up contents come from a built-in default program image.

---
 rtl/program_memory.sv | 38 +++
 tb/tb_program_memory.sv | 116 +++++++++++
 2 files changed

// File: rtl/program_memory.sv
// Never8 program store: 256 x 8 RAM with a registered, read-first read port
// indexed by the PC and a synchronous load port. Powers up holding the default image.
module program_memory #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Default image: a single 0x01 at the reset vector, NOP everywhere else.
    // The array carries no reset so rst never disturbs loaded code.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{0: DATA_WIDTH'(8'h01), default: {DATA_WIDTH{1'b0}}};

    // Load port; suppressed while the block is held in reset
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; sampling the array before the write lands gives read-first behaviour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= {DATA_WIDTH{1'b0}};
        end else begin
            data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: directed scenarios followed by
// randomized traffic checked against an array-based model of the memory.
module tb_program_memory;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] address;
    logic       we;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] data_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] exp_q;

    program_memory dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock edge: predict the output from the model, apply the write, sample #1 after the edge
    task automatic tick();
        logic [7:0] e;
        e = rst ? 8'h00 : ref_mem[address];
        if (we && !rst) ref_mem[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        exp_q = e;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[0] = 8'h01;

        rst = 1'b0; address = 8'h00; we = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
        #2 rst = 1'b1;
        #1 check("reset_async_initial", data_out, 8'h00);
        tick(); check("reset_hold", data_out, 8'h00);
        rst = 1'b0;

        // Power-up image
        address = 8'h00; tick(); check("powerup_addr00", data_out, 8'h01);
        address = 8'h05; tick(); check("default_addr05", data_out, 8'h00);
        address = 8'hFF; tick(); check("default_addrFF", data_out, 8'h00);

        // Load and read back
        we = 1'b1; wr_addr = 8'h10; wr_data = 8'hA5; address = 8'h00; tick();
        check("load_cycle_read00", data_out, 8'h01);
        we = 1'b0; address = 8'h10; tick(); check("readback_10", data_out, 8'hA5);

        // Read-during-write returns old data, new data next cycle
        we = 1'b1; wr_addr = 8'h10; wr_data = 8'h3C; address = 8'h10; tick();
        check("rdw_old", data_out, 8'hA5);
        we = 1'b0; tick(); check("rdw_new", data_out, 8'h3C);

        // Asynchronous reset between edges, writes blocked while held
        #2 rst = 1'b1;
        #1 check("async_reset_midcycle", data_out, 8'h00);
        we = 1'b1; wr_addr = 8'h00; wr_data = 8'hFF;
        tick(); check("reset_write_blk1", data_out, 8'h00);
        tick(); check("reset_write_blk2", data_out, 8'h00);
        rst = 1'b0; we = 1'b0; address = 8'h00;
        tick(); check("post_reset_addr00", data_out, 8'h01);
        address = 8'h10; tick(); check("post_reset_mem10", data_out, 8'h3C);

        // Latency sequence
        address = 8'h00; tick(); check("lat_00", data_out, 8'h01);
        address = 8'h10; tick(); check("lat_10", data_out, 8'h3C);
        address = 8'h05; tick(); check("lat_05", data_out, 8'h00);

        // Independent read and write addresses in the same cycle
        we = 1'b1; wr_addr = 8'hFF; wr_data = 8'h5A; address = 8'h10; tick();
        check("indep_read10", data_out, 8'h3C);
        we = 1'b0; address = 8'hFF; tick(); check("indep_readFF", data_out, 8'h5A);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            we      = ($urandom_range(0, 1) == 1);
            wr_data = 8'($urandom);
            address = 8'($urandom);
            wr_addr = ($urandom_range(0, 3) == 0) ? address : 8'($urandom);
            rst     = ($urandom_range(0, 31) == 0);
            tick();
            check("random", data_out, exp_q);
        end

        rst = 1'b0; we = 1'b0;
        for (int a = 0; a < 256; a += 17) begin
            address = 8'(a);
            tick();
            check("final_sweep", data_out, exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
